id_stage_pipe: RTL and testbench

Next-generation decode stage for the DPCPU pipeline. It holds the IF/ID and ID/EX pipeline registers and the register file. It also contains the hazard logic: EX/MEM forwarding, load-use interlock and in-ID branch/jump resolution with squash of the wrong-path fetch. Fetch sits upstream and the EX stage downstream. The instruction field layout is unchanged: op[31:26], func[25:20], rd[14:10], rs[9:5], rt[4:0], imm16[25:10], jump index[25:0].

---
 rtl/isa_pkg.sv | 76 +++++++
 rtl/id_ctrl_decode.sv | 64 ++++++
 rtl/id_regfile.sv | 38 +++
 rtl/id_stage_pipe.sv | 177 +++++++++++++++++
 tb/tb_id_stage_pipe.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - DPCPU ISA constants, decode control bundle and field slices
// Purpose: shared opcode/func encodings, ALU op codes, PC source codes and
//          instruction field positions for the decode stage.
// Ports:   none (package).
package isa_pkg;

    // Instruction field positions
    localparam int OP_HI   = 31;
    localparam int OP_LO   = 26;
    localparam int FUNC_HI = 25;
    localparam int FUNC_LO = 20;
    localparam int RD_HI   = 14;
    localparam int RD_LO   = 10;
    localparam int RS_HI   = 9;
    localparam int RS_LO   = 5;
    localparam int RT_HI   = 4;
    localparam int RT_LO   = 0;
    localparam int IMM_HI  = 25;
    localparam int IMM_LO  = 10;
    localparam int JIDX_HI = 25;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type func codes
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_SRA = 6'h03;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;

    // ALU operations
    localparam logic [2:0] ALUC_ADD = 3'd0;
    localparam logic [2:0] ALUC_SUB = 3'd1;
    localparam logic [2:0] ALUC_AND = 3'd2;
    localparam logic [2:0] ALUC_OR  = 3'd3;
    localparam logic [2:0] ALUC_SLL = 3'd4;
    localparam logic [2:0] ALUC_SRL = 3'd5;
    localparam logic [2:0] ALUC_SRA = 3'd6;

    // Next-PC source select
    localparam logic [1:0] PCSRC_PC4 = 2'b00;
    localparam logic [1:0] PCSRC_BPC = 2'b01;
    localparam logic [1:0] PCSRC_JPC = 2'b10;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_BEQ  = 2'd1,
        BR_BNE  = 2'd2,
        BR_J    = 2'd3
    } br_t;

    typedef struct packed {
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic [2:0] aluc;
        logic       regrt;   // destination is rt instead of rd
        logic       aluimm;  // ALU B operand is the immediate
        logic       sext;    // sign-extend imm16 (else zero-extend)
        logic       shift;
        logic       use_rt;  // rt is a source operand
        br_t        br;
    } ctrl_t;

endpackage

// File: rtl/id_ctrl_decode.sv
// rtl/id_ctrl_decode.sv - combinational opcode/func to control bundle decoder
// Purpose: maps op/func to the ID control bundle; unknown encodings decode
//          to a NOP (no register write, no memory access, no branch).
// Ports:   op, func in; ctrl out (isa_pkg::ctrl_t).
module id_ctrl_decode
    import isa_pkg::*;
(
    input  logic [5:0] op,
    input  logic [5:0] func,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl      = '0;
        ctrl.sext = 1'b1;
        ctrl.br   = BR_NONE;
        case (op)
            OP_RTYPE: begin
                ctrl.use_rt = 1'b1;
                case (func)
                    FN_ADD: begin ctrl.wreg = 1'b1; ctrl.aluc = ALUC_ADD; end
                    FN_SUB: begin ctrl.wreg = 1'b1; ctrl.aluc = ALUC_SUB; end
                    FN_AND: begin ctrl.wreg = 1'b1; ctrl.aluc = ALUC_AND; end
                    FN_OR:  begin ctrl.wreg = 1'b1; ctrl.aluc = ALUC_OR;  end
                    FN_SLL: begin ctrl.wreg = 1'b1; ctrl.aluc = ALUC_SLL; ctrl.shift = 1'b1; end
                    FN_SRL: begin ctrl.wreg = 1'b1; ctrl.aluc = ALUC_SRL; ctrl.shift = 1'b1; end
                    FN_SRA: begin ctrl.wreg = 1'b1; ctrl.aluc = ALUC_SRA; ctrl.shift = 1'b1; end
                    default: ;
                endcase
            end
            OP_ADDI: begin
                ctrl.wreg = 1'b1; ctrl.regrt = 1'b1; ctrl.aluimm = 1'b1;
                ctrl.aluc = ALUC_ADD;
            end
            OP_ANDI: begin
                ctrl.wreg = 1'b1; ctrl.regrt = 1'b1; ctrl.aluimm = 1'b1;
                ctrl.aluc = ALUC_AND; ctrl.sext = 1'b0;
            end
            OP_ORI: begin
                ctrl.wreg = 1'b1; ctrl.regrt = 1'b1; ctrl.aluimm = 1'b1;
                ctrl.aluc = ALUC_OR; ctrl.sext = 1'b0;
            end
            OP_LW: begin
                ctrl.wreg = 1'b1; ctrl.m2reg = 1'b1; ctrl.regrt = 1'b1;
                ctrl.aluimm = 1'b1; ctrl.aluc = ALUC_ADD;
            end
            OP_SW: begin
                ctrl.wmem = 1'b1; ctrl.aluimm = 1'b1; ctrl.use_rt = 1'b1;
                ctrl.aluc = ALUC_ADD;
            end
            OP_BEQ: begin
                ctrl.use_rt = 1'b1; ctrl.aluc = ALUC_SUB; ctrl.br = BR_BEQ;
            end
            OP_BNE: begin
                ctrl.use_rt = 1'b1; ctrl.aluc = ALUC_SUB; ctrl.br = BR_BNE;
            end
            OP_J: begin
                ctrl.br = BR_J;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_regfile.sv
// rtl/id_regfile.sv - 32 x XLEN register file, 2 read / 1 write, optional WB bypass
// Purpose: architectural registers; r0 is hardwired to zero.
// Ports:   clk, clrn (sync active-high clear); ra1/ra2 -> rd1/rd2 read ports;
//          we/wn/wd write port (written on rising edge).
module id_regfile #(
    parameter int XLEN      = 32,
    parameter bit RF_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    output logic [XLEN-1:0] rd1,
    output logic [XLEN-1:0] rd2,
    input  logic            we,
    input  logic [4:0]      wn,
    input  logic [XLEN-1:0] wd
);

    logic [XLEN-1:0] regs [32];

    always_ff @(posedge clk) begin
        if (clrn) begin
            for (int i = 0; i < 32; i++) regs[i] <= '0;
        end else if (we && wn != 5'd0) begin
            regs[wn] <= wd;
        end
    end

    // Write-before-read: a same-cycle writeback is returned directly
    always_comb begin
        rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
        rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
        if (RF_BYPASS && we && wn != 5'd0 && wn == ra1) rd1 = wd;
        if (RF_BYPASS && we && wn != 5'd0 && wn == ra2) rd2 = wd;
    end

endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - DPCPU decode stage: IF/ID and ID/EX registers, hazards, branch resolve
// Purpose: decodes the instruction in IF/ID, selects forwarded operands,
//          interlocks on load-use (or on any RAW when forwarding is off),
//          resolves BEQ/BNE/J in ID and squashes the wrong-path fetch.
// Ports:   clk/clrn; if_valid/if_pc4/if_inst from fetch; id_ready/redirect/
//          pcsource/target to fetch; ex_stall, ex_*/mem_*/wb_* hazard and
//          writeback inputs; de_* ID/EX register outputs.
module id_stage_pipe
    import isa_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit FWD_EN    = 1'b1,
    parameter bit RF_BYPASS = 1'b1
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_pc4,
    input  logic [31:0]     if_inst,
    output logic            id_ready,
    output logic            redirect,
    output logic [1:0]      pcsource,
    output logic [XLEN-1:0] target,
    input  logic            ex_stall,
    input  logic            ex_wreg,
    input  logic            ex_m2reg,
    input  logic [4:0]      ex_rn,
    input  logic [XLEN-1:0] ex_alu,
    input  logic            mem_wreg,
    input  logic [4:0]      mem_rn,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_we,
    input  logic [4:0]      wb_rn,
    input  logic [XLEN-1:0] wb_data,
    output logic            de_valid,
    output logic            de_wreg,
    output logic            de_m2reg,
    output logic            de_wmem,
    output logic            de_aluimm,
    output logic            de_shift,
    output logic [2:0]      de_aluc,
    output logic [4:0]      de_rn,
    output logic [XLEN-1:0] de_a,
    output logic [XLEN-1:0] de_b,
    output logic [XLEN-1:0] de_imm,
    output logic [XLEN-1:0] de_pc4
);

    logic            fd_valid;
    logic [31:0]     fd_inst;
    logic [XLEN-1:0] fd_pc4;

    logic [5:0]      op, func;
    logic [4:0]      rs, rt, rd;
    logic [15:0]     imm16;
    ctrl_t           ctrl;
    logic [XLEN-1:0] rf_a, rf_b, opa, opb, imm_ext, bpc, jpc;
    logic            ex_hit, mem_hit, wb_hit, load_use, raw_hit, stall, take;

    assign op    = fd_inst[OP_HI:OP_LO];
    assign func  = fd_inst[FUNC_HI:FUNC_LO];
    assign rd    = fd_inst[RD_HI:RD_LO];
    assign rs    = fd_inst[RS_HI:RS_LO];
    assign rt    = fd_inst[RT_HI:RT_LO];
    assign imm16 = fd_inst[IMM_HI:IMM_LO];

    id_ctrl_decode u_dec (
        .op   (op),
        .func (func),
        .ctrl (ctrl)
    );

    id_regfile #(.XLEN(XLEN), .RF_BYPASS(RF_BYPASS)) u_rf (
        .clk  (clk),
        .clrn (clrn),
        .ra1  (rs),
        .ra2  (rt),
        .rd1  (rf_a),
        .rd2  (rf_b),
        .we   (wb_we),
        .wn   (wb_rn),
        .wd   (wb_data)
    );

    // Operand select: youngest producer wins; r0 is never forwarded.
    // A load in EX has no data yet, so it is excluded (load-use stalls instead).
    always_comb begin
        opa = rf_a;
        if (rs == 5'd0)                                           opa = '0;
        else if (FWD_EN && ex_wreg && !ex_m2reg && ex_rn == rs)   opa = ex_alu;
        else if (FWD_EN && mem_wreg && mem_rn == rs)              opa = mem_data;
        else if (FWD_EN && wb_we && wb_rn == rs)                  opa = wb_data;
    end

    always_comb begin
        opb = rf_b;
        if (rt == 5'd0)                                           opb = '0;
        else if (FWD_EN && ex_wreg && !ex_m2reg && ex_rn == rt)   opb = ex_alu;
        else if (FWD_EN && mem_wreg && mem_rn == rt)              opb = mem_data;
        else if (FWD_EN && wb_we && wb_rn == rt)                  opb = wb_data;
    end

    // Hazard detection against the sources this instruction actually reads
    assign ex_hit   = (ex_rn  != 5'd0) && (ex_rn  == rs || (ctrl.use_rt && ex_rn  == rt));
    assign mem_hit  = (mem_rn != 5'd0) && (mem_rn == rs || (ctrl.use_rt && mem_rn == rt));
    assign wb_hit   = (wb_rn  != 5'd0) && (wb_rn  == rs || (ctrl.use_rt && wb_rn  == rt));
    assign load_use = ex_wreg && ex_m2reg && ex_hit;
    assign raw_hit  = (ex_wreg && ex_hit) || (mem_wreg && mem_hit) || (wb_we && wb_hit);
    assign stall    = fd_valid && (FWD_EN ? load_use : raw_hit);
    assign id_ready = !stall && !ex_stall;

    assign imm_ext = ctrl.sext ? {{(XLEN-16){imm16[15]}}, imm16} : {{(XLEN-16){1'b0}}, imm16};
    assign bpc     = fd_pc4 + (imm_ext << 2);
    assign jpc     = {fd_pc4[XLEN-1:28], fd_inst[JIDX_HI:0], 2'b00};

    // Branch resolves only when the instruction will actually advance
    assign take = fd_valid && !stall && !ex_stall &&
                  ((ctrl.br == BR_BEQ && opa == opb) ||
                   (ctrl.br == BR_BNE && opa != opb) ||
                   (ctrl.br == BR_J));

    assign redirect = take;
    assign pcsource = !take ? PCSRC_PC4 : (ctrl.br == BR_J) ? PCSRC_JPC : PCSRC_BPC;
    assign target   = !take ? fd_pc4    : (ctrl.br == BR_J) ? jpc       : bpc;

    // IF/ID register; the fetch behind a taken branch is dropped
    always_ff @(posedge clk) begin
        if (clrn) begin
            fd_valid <= 1'b0;
            fd_inst  <= '0;
            fd_pc4   <= '0;
        end else if (id_ready) begin
            fd_valid <= if_valid && !redirect;
            fd_inst  <= if_inst;
            fd_pc4   <= if_pc4;
        end
    end

    // ID/EX register; frozen by ex_stall, bubble on stall or empty IF/ID
    always_ff @(posedge clk) begin
        if (clrn) begin
            de_valid  <= 1'b0;
            de_wreg   <= 1'b0;
            de_m2reg  <= 1'b0;
            de_wmem   <= 1'b0;
            de_aluimm <= 1'b0;
            de_shift  <= 1'b0;
            de_aluc   <= '0;
            de_rn     <= '0;
            de_a      <= '0;
            de_b      <= '0;
            de_imm    <= '0;
            de_pc4    <= '0;
        end else if (!ex_stall) begin
            if (fd_valid && !stall) begin
                de_valid  <= 1'b1;
                de_wreg   <= ctrl.wreg;
                de_m2reg  <= ctrl.m2reg;
                de_wmem   <= ctrl.wmem;
                de_aluimm <= ctrl.aluimm;
                de_shift  <= ctrl.shift;
                de_aluc   <= ctrl.aluc;
                de_rn     <= ctrl.regrt ? rt : rd;
                de_a      <= opa;
                de_b      <= opb;
                de_imm    <= imm_ext;
                de_pc4    <= fd_pc4;
            end else begin
                de_valid <= 1'b0;
                de_wreg  <= 1'b0;
                de_m2reg <= 1'b0;
                de_wmem  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed self-checking bench for id_stage_pipe
module tb_id_stage_pipe;
    import isa_pkg::*;

    logic        clk = 1'b0;
    logic        clrn;
    logic        if_valid;
    logic [31:0] if_pc4, if_inst;
    logic        ex_stall, ex_wreg, ex_m2reg, mem_wreg, wb_we;
    logic [4:0]  ex_rn, mem_rn, wb_rn;
    logic [31:0] ex_alu, mem_data, wb_data;

    logic        id_ready, redirect, de_valid, de_wreg, de_m2reg, de_wmem, de_aluimm, de_shift;
    logic [1:0]  pcsource;
    logic [2:0]  de_aluc;
    logic [4:0]  de_rn;
    logic [31:0] target, de_a, de_b, de_imm, de_pc4;

    logic        u1_id_ready, u1_redirect, u1_de_valid, u1_de_wreg, u1_de_m2reg, u1_de_wmem;
    logic        u1_de_aluimm, u1_de_shift;
    logic [1:0]  u1_pcsource;
    logic [2:0]  u1_de_aluc;
    logic [4:0]  u1_de_rn;
    logic [31:0] u1_target, u1_de_a, u1_de_b, u1_de_imm, u1_de_pc4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    id_stage_pipe #(.XLEN(32), .FWD_EN(1'b1), .RF_BYPASS(1'b1)) u0 (
        .clk(clk), .clrn(clrn), .if_valid(if_valid), .if_pc4(if_pc4), .if_inst(if_inst),
        .id_ready(id_ready), .redirect(redirect), .pcsource(pcsource), .target(target),
        .ex_stall(ex_stall), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn), .ex_alu(ex_alu),
        .mem_wreg(mem_wreg), .mem_rn(mem_rn), .mem_data(mem_data),
        .wb_we(wb_we), .wb_rn(wb_rn), .wb_data(wb_data),
        .de_valid(de_valid), .de_wreg(de_wreg), .de_m2reg(de_m2reg), .de_wmem(de_wmem),
        .de_aluimm(de_aluimm), .de_shift(de_shift), .de_aluc(de_aluc), .de_rn(de_rn),
        .de_a(de_a), .de_b(de_b), .de_imm(de_imm), .de_pc4(de_pc4)
    );

    id_stage_pipe #(.XLEN(32), .FWD_EN(1'b0), .RF_BYPASS(1'b1)) u1 (
        .clk(clk), .clrn(clrn), .if_valid(if_valid), .if_pc4(if_pc4), .if_inst(if_inst),
        .id_ready(u1_id_ready), .redirect(u1_redirect), .pcsource(u1_pcsource), .target(u1_target),
        .ex_stall(ex_stall), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg), .ex_rn(ex_rn), .ex_alu(ex_alu),
        .mem_wreg(mem_wreg), .mem_rn(mem_rn), .mem_data(mem_data),
        .wb_we(wb_we), .wb_rn(wb_rn), .wb_data(wb_data),
        .de_valid(u1_de_valid), .de_wreg(u1_de_wreg), .de_m2reg(u1_de_m2reg), .de_wmem(u1_de_wmem),
        .de_aluimm(u1_de_aluimm), .de_shift(u1_de_shift), .de_aluc(u1_de_aluc), .de_rn(u1_de_rn),
        .de_a(u1_de_a), .de_b(u1_de_b), .de_imm(u1_de_imm), .de_pc4(u1_de_pc4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rtype(input logic [5:0] fn, input logic [4:0] rd_, input logic [4:0] rs_, input logic [4:0] rt_);
        return {OP_RTYPE, fn, 5'd0, rd_, rs_, rt_};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op_, input logic [15:0] imm, input logic [4:0] rs_, input logic [4:0] rt_);
        return {op_, imm, rs_, rt_};
    endfunction

    // Present one instruction for a single cycle, then let it reach ID/EX
    task automatic issue(input logic [31:0] inst, input logic [31:0] pc4);
        if_valid = 1'b1; if_inst = inst; if_pc4 = pc4;
        tick();
        if_valid = 1'b0;
        tick();
    endtask

    initial begin
        clrn = 1'b1; if_valid = 1'b0; if_pc4 = '0; if_inst = '0; ex_stall = 1'b0;
        ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_rn = '0; ex_alu = '0;
        mem_wreg = 1'b0; mem_rn = '0; mem_data = '0; wb_we = 1'b0; wb_rn = '0; wb_data = '0;
        tick(); tick();
        clrn = 1'b0;
        #1;
        check("rst_de_valid", {31'd0, de_valid}, 32'd0);
        check("rst_de_a", de_a, 32'd0);
        check("rst_de_rn", {27'd0, de_rn}, 32'd0);
        check("rst_redirect", {31'd0, redirect}, 32'd0);
        check("rst_pcsource", {30'd0, pcsource}, 32'd0);
        check("rst_id_ready", {31'd0, id_ready}, 32'd1);

        // ADDI r1,r0,5
        issue(itype(OP_ADDI, 16'd5, 5'd0, 5'd1), 32'h4);
        check("addi_valid", {31'd0, de_valid}, 32'd1);
        check("addi_a", de_a, 32'd0);
        check("addi_imm", de_imm, 32'd5);
        check("addi_rn", {27'd0, de_rn}, 32'd1);
        check("addi_aluimm", {31'd0, de_aluimm}, 32'd1);
        check("addi_wreg", {31'd0, de_wreg}, 32'd1);
        check("addi_pc4", de_pc4, 32'h4);

        // EX forwarding: ADD r2,r1,r1 with EX producing r1=7
        ex_wreg = 1'b1; ex_rn = 5'd1; ex_alu = 32'd7;
        issue(rtype(FN_ADD, 5'd2, 5'd1, 5'd1), 32'h8);
        check("fwd_ex_a", de_a, 32'd7);
        check("fwd_ex_b", de_b, 32'd7);
        check("fwd_ex_rn", {27'd0, de_rn}, 32'd2);
        check("fwd_ex_aluimm", {31'd0, de_aluimm}, 32'd0);

        // Load-use: LW r3 in EX, ADD r4,r3,r0 in ID
        ex_wreg = 1'b1; ex_m2reg = 1'b1; ex_rn = 5'd3; ex_alu = 32'hDEAD;
        if_valid = 1'b1; if_inst = rtype(FN_ADD, 5'd4, 5'd3, 5'd0); if_pc4 = 32'hC;
        tick();
        if_valid = 1'b0;
        #1;
        check("lu_id_ready", {31'd0, id_ready}, 32'd0);
        tick();
        check("lu_bubble", {31'd0, de_valid}, 32'd0);
        ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_rn = '0;
        mem_wreg = 1'b1; mem_rn = 5'd3; mem_data = 32'd9;
        #1;
        check("lu_release", {31'd0, id_ready}, 32'd1);
        tick();
        check("lu_mem_a", de_a, 32'd9);
        check("lu_valid", {31'd0, de_valid}, 32'd1);
        check("lu_rn", {27'd0, de_rn}, 32'd4);
        mem_wreg = 1'b0; mem_rn = '0; mem_data = '0;

        // BEQ r1,r1,+4 at pc4=0x100: taken, wrong-path fetch squashed
        if_valid = 1'b1; if_inst = itype(OP_BEQ, 16'd4, 5'd1, 5'd1); if_pc4 = 32'h100;
        tick();
        if_inst = itype(OP_ADDI, 16'd1, 5'd0, 5'd5); if_pc4 = 32'h104;
        #1;
        check("beq_redirect", {31'd0, redirect}, 32'd1);
        check("beq_pcsource", {30'd0, pcsource}, 32'd1);
        check("beq_target", target, 32'h110);
        tick();
        if_valid = 1'b0;
        check("beq_de_valid", {31'd0, de_valid}, 32'd1);
        check("beq_no_redirect_after", {31'd0, redirect}, 32'd0);
        tick();
        check("beq_squash", {31'd0, de_valid}, 32'd0);

        // BNE with equal operands: not taken
        if_valid = 1'b1; if_inst = itype(OP_BNE, 16'd4, 5'd1, 5'd1); if_pc4 = 32'h200;
        tick();
        if_valid = 1'b0;
        #1;
        check("bne_redirect", {31'd0, redirect}, 32'd0);
        check("bne_pcsource", {30'd0, pcsource}, 32'd0);
        tick();

        // J 0x40 at pc4=0x80000004
        if_valid = 1'b1; if_inst = {OP_J, 26'h40}; if_pc4 = 32'h8000_0004;
        tick();
        if_valid = 1'b0;
        #1;
        check("j_redirect", {31'd0, redirect}, 32'd1);
        check("j_pcsource", {30'd0, pcsource}, 32'd2);
        check("j_target", target, 32'h8000_0100);
        tick();

        // Writes: r0 ignored, r1 = 0x1234
        wb_we = 1'b1; wb_rn = 5'd0; wb_data = 32'hFFFF_FFFF;
        tick();
        wb_rn = 5'd1; wb_data = 32'h1234;
        tick();
        wb_we = 1'b0; wb_rn = '0; wb_data = '0;
        issue(rtype(FN_ADD, 5'd6, 5'd1, 5'd0), 32'h300);
        check("rf_r1", de_a, 32'h1234);
        check("rf_r0", de_b, 32'd0);

        // ex_stall holds everything for 3 cycles
        ex_stall = 1'b1;
        if_valid = 1'b1; if_inst = itype(OP_ADDI, 16'd3, 5'd0, 5'd9); if_pc4 = 32'h400;
        #1;
        check("exst_id_ready", {31'd0, id_ready}, 32'd0);
        tick(); tick(); tick();
        check("exst_de_valid", {31'd0, de_valid}, 32'd1);
        check("exst_de_rn", {27'd0, de_rn}, 32'd6);
        check("exst_de_a", de_a, 32'h1234);
        check("exst_de_pc4", de_pc4, 32'h300);
        ex_stall = 1'b0;
        tick();
        if_valid = 1'b0;
        tick();
        check("exst_resume_rn", {27'd0, de_rn}, 32'd9);
        check("exst_resume_imm", de_imm, 32'd3);

        // Immediate extension, store, shift, unknown op
        issue(itype(OP_ANDI, 16'h8000, 5'd0, 5'd2), 32'h500);
        check("andi_zext", de_imm, 32'h0000_8000);
        issue(itype(OP_ADDI, 16'hFFFC, 5'd0, 5'd2), 32'h504);
        check("addi_sext", de_imm, 32'hFFFF_FFFC);
        issue(itype(OP_SW, 16'd8, 5'd0, 5'd1), 32'h508);
        check("sw_wmem", {31'd0, de_wmem}, 32'd1);
        check("sw_wreg", {31'd0, de_wreg}, 32'd0);
        check("sw_b", de_b, 32'h1234);
        issue(rtype(FN_SLL, 5'd3, 5'd1, 5'd0), 32'h50C);
        check("sll_shift", {31'd0, de_shift}, 32'd1);
        check("sll_aluc", {29'd0, de_aluc}, 32'd4);
        issue(32'hFC00_0021, 32'h510);
        check("unk_valid", {31'd0, de_valid}, 32'd1);
        check("unk_wreg", {31'd0, de_wreg}, 32'd0);
        check("unk_wmem", {31'd0, de_wmem}, 32'd0);
        check("unk_m2reg", {31'd0, de_m2reg}, 32'd0);

        // FWD_EN=0 instance interlocks until writeback completes
        clrn = 1'b1;
        tick();
        clrn = 1'b0;
        ex_wreg = 1'b1; ex_rn = 5'd1; ex_alu = 32'd7;
        if_valid = 1'b1; if_inst = rtype(FN_ADD, 5'd2, 5'd1, 5'd1); if_pc4 = 32'h600;
        tick();
        if_valid = 1'b0;
        #1;
        check("nf_ready_ex", {31'd0, u1_id_ready}, 32'd0);
        ex_wreg = 1'b0; ex_rn = '0; ex_alu = '0;
        mem_wreg = 1'b1; mem_rn = 5'd1; mem_data = 32'd7;
        tick();
        check("nf_bubble_ex", {31'd0, u1_de_valid}, 32'd0);
        check("nf_ready_mem", {31'd0, u1_id_ready}, 32'd0);
        check("fwd_mem_a", de_a, 32'd7);
        mem_wreg = 1'b0; mem_rn = '0; mem_data = '0;
        wb_we = 1'b1; wb_rn = 5'd1; wb_data = 32'd7;
        tick();
        check("nf_bubble_mem", {31'd0, u1_de_valid}, 32'd0);
        wb_we = 1'b0; wb_rn = '0; wb_data = '0;
        tick();
        check("nf_de_valid", {31'd0, u1_de_valid}, 32'd1);
        check("nf_de_a", u1_de_a, 32'd7);
        check("nf_de_b", u1_de_b, 32'd7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
